// File: rtl/phy_tx_scheduler.sv
// phy_tx_scheduler: packet-granular arbiter of ordered-set and DLLP streams with SKP interval scheduling
module phy_tx_scheduler #(
  parameter int DATA_WIDTH    = 32,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int USER_WIDTH    = 5,
  parameter int SKP_INTERVAL  = 1180,
  parameter int SKP_CNT_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  link_up_i,
  input  logic                  skp_en_i,
  input  logic [DATA_WIDTH-1:0] s_os_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_os_axis_tkeep,
  input  logic                  s_os_axis_tvalid,
  input  logic                  s_os_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_os_axis_tuser,
  output logic                  s_os_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_dllp_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_dllp_axis_tkeep,
  input  logic                  s_dllp_axis_tvalid,
  input  logic                  s_dllp_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_dllp_axis_tuser,
  output logic                  s_dllp_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic                  skp_req_o,
  input  logic                  skp_ack_i,
  output logic [1:0]            grant_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, OS_PKT = 2'd1, DLLP_PKT = 2'd2, SKP_WAIT = 2'd3} state_t;
  state_t state, state_nxt;
  logic [SKP_CNT_WIDTH-1:0] cnt;
  logic [1:0] pending;
  logic os_sel, dllp_sel, run, tick, ack;
  assign os_sel    = state == OS_PKT;
  assign dllp_sel  = state == DLLP_PKT;
  assign run       = link_up_i & skp_en_i;
  assign tick      = run && cnt == SKP_CNT_WIDTH'(SKP_INTERVAL - 1);
  assign ack       = state == SKP_WAIT && skp_ack_i;
  assign skp_req_o = state == SKP_WAIT;
  assign grant_o   = state;
  always_comb begin
    m_axis_tdata       = dllp_sel ? s_dllp_axis_tdata : s_os_axis_tdata;
    m_axis_tkeep       = dllp_sel ? s_dllp_axis_tkeep : s_os_axis_tkeep;
    m_axis_tlast       = dllp_sel ? s_dllp_axis_tlast : s_os_axis_tlast;
    m_axis_tuser       = dllp_sel ? s_dllp_axis_tuser : s_os_axis_tuser;
    m_axis_tvalid      = (os_sel & s_os_axis_tvalid) | (dllp_sel & s_dllp_axis_tvalid);
    s_os_axis_tready   = os_sel & m_axis_tready;
    s_dllp_axis_tready = dllp_sel & m_axis_tready;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     state_nxt = s_os_axis_tvalid ? OS_PKT :
                            |pending ? SKP_WAIT :
                            (s_dllp_axis_tvalid & link_up_i) ? DLLP_PKT : IDLE;
      OS_PKT:   state_nxt = (s_os_axis_tvalid & m_axis_tready & s_os_axis_tlast) ? IDLE : OS_PKT;
      DLLP_PKT: state_nxt = (s_dllp_axis_tvalid & m_axis_tready & s_dllp_axis_tlast) ? IDLE : DLLP_PKT;
      SKP_WAIT: state_nxt = (!link_up_i || skp_ack_i) ? IDLE : SKP_WAIT;
      default:  state_nxt = IDLE;
    endcase
  end
  // a tick and an ack on the same edge cancel; the pending count saturates at 3
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= !link_up_i ? '0 : !run ? cnt : tick ? '0 : cnt + 1'b1;
      pending <= !link_up_i ? 2'd0 :
                 (tick && !ack && pending != 2'd3) ? pending + 2'd1 :
                 (ack && !tick && pending != 2'd0) ? pending - 2'd1 : pending;
    end
  end
endmodule

// File: tb/tb_phy_tx_scheduler.sv
// tb_phy_tx_scheduler: directed scenario tests of the tx scheduler with SKP_INTERVAL=8
module tb_phy_tx_scheduler;
  logic        clk = 0;
  logic        rst_i = 1;
  logic        link_up_i = 0, skp_en_i = 0;
  logic [31:0] s_os_axis_tdata = 0, s_dllp_axis_tdata = 0, m_axis_tdata;
  logic [3:0]  s_os_axis_tkeep = 4'hf, s_dllp_axis_tkeep = 4'hf, m_axis_tkeep;
  logic [4:0]  s_os_axis_tuser = 5'h01, s_dllp_axis_tuser = 5'h02, m_axis_tuser;
  logic        s_os_axis_tvalid = 0, s_os_axis_tlast = 0, s_os_axis_tready;
  logic        s_dllp_axis_tvalid = 0, s_dllp_axis_tlast = 0, s_dllp_axis_tready;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready = 0;
  logic        skp_req_o, skp_ack_i = 0;
  logic [1:0]  grant_o;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  phy_tx_scheduler #(.DATA_WIDTH(32), .USER_WIDTH(5), .SKP_INTERVAL(8), .SKP_CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .link_up_i(link_up_i), .skp_en_i(skp_en_i),
    .s_os_axis_tdata(s_os_axis_tdata), .s_os_axis_tkeep(s_os_axis_tkeep), .s_os_axis_tvalid(s_os_axis_tvalid),
    .s_os_axis_tlast(s_os_axis_tlast), .s_os_axis_tuser(s_os_axis_tuser), .s_os_axis_tready(s_os_axis_tready),
    .s_dllp_axis_tdata(s_dllp_axis_tdata), .s_dllp_axis_tkeep(s_dllp_axis_tkeep), .s_dllp_axis_tvalid(s_dllp_axis_tvalid),
    .s_dllp_axis_tlast(s_dllp_axis_tlast), .s_dllp_axis_tuser(s_dllp_axis_tuser), .s_dllp_axis_tready(s_dllp_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .skp_req_o(skp_req_o), .skp_ack_i(skp_ack_i), .grant_o(grant_o)
  );

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic link_reset;
    link_up_i = 0;
    skp_en_i = 0;
    skp_ack_i = 0;
    s_os_axis_tvalid = 0;
    s_dllp_axis_tvalid = 0;
    s_dllp_axis_tlast = 0;
    repeat (3) cyc;
  endtask

  task automatic test_reset;
    link_up_i = 1;
    s_os_axis_tvalid = 1;
    s_dllp_axis_tvalid = 1;
    m_axis_tready = 1;
    for (int i = 0; i < 3; i++) begin
      cyc;
      #1;
      checks++;
      if ({s_os_axis_tready, s_dllp_axis_tready, m_axis_tvalid, skp_req_o, grant_o} !== 6'b0) begin
        errors++;
        $display("FAIL reset_outputs: got os_rdy=%b dllp_rdy=%b m_valid=%b skp_req=%b grant=%0d required all 0",
                 s_os_axis_tready, s_dllp_axis_tready, m_axis_tvalid, skp_req_o, grant_o);
      end
    end
    rst_i = 0;
    cyc;
    #1;
    checks++;
    if (grant_o !== 2'd1 || m_axis_tvalid !== 1'b1 || s_dllp_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_os_first: got grant=%0d m_valid=%b dllp_rdy=%b required 1 1 0", grant_o, m_axis_tvalid, s_dllp_axis_tready);
    end
    s_dllp_axis_tvalid = 0;
    rst_i = 1;
    cyc;
    #1;
    checks++;
    if (grant_o !== 2'd0 || m_axis_tvalid !== 1'b0 || s_os_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_packet: got grant=%0d m_valid=%b os_rdy=%b required 0 0 0", grant_o, m_axis_tvalid, s_os_axis_tready);
    end
    rst_i = 0;
    s_os_axis_tvalid = 0;
    link_reset;
  endtask

  task automatic test_dllp_packet;
    logic [4:0] pat = 5'b11101;
    int idx = 0;
    link_up_i = 1;
    m_axis_tready = 1;
    s_dllp_axis_tvalid = 1;
    s_dllp_axis_tdata = 32'hA000_0000;
    s_dllp_axis_tlast = 0;
    cyc;
    for (int c = 0; c < 5; c++) begin
      m_axis_tready = pat[c];
      s_dllp_axis_tdata = 32'hA000_0000 + idx;
      s_dllp_axis_tlast = idx == 3;
      if (idx >= 2) s_os_axis_tvalid = 1;
      #1;
      checks++;
      if (grant_o !== 2'd2 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hA000_0000 + idx ||
          m_axis_tlast !== (idx == 3) || m_axis_tuser !== 5'h02 ||
          s_dllp_axis_tready !== pat[c] || s_os_axis_tready !== 1'b0) begin
        errors++;
        $display("FAIL dllp_beat%0d: got grant=%0d valid=%b data=%h last=%b user=%h dllp_rdy=%b os_rdy=%b required 2 1 %h %b 02 %b 0",
                 c, grant_o, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, s_dllp_axis_tready, s_os_axis_tready,
                 32'hA000_0000 + idx, idx == 3, pat[c]);
      end
      cyc;
      if (pat[c]) idx++;
    end
    s_dllp_axis_tvalid = 0;
    s_dllp_axis_tlast = 0;
    #1;
    checks++;
    if (grant_o !== 2'd0 || m_axis_tvalid !== 1'b0 || s_os_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL dllp_idle_gap: got grant=%0d m_valid=%b os_rdy=%b required 0 0 0", grant_o, m_axis_tvalid, s_os_axis_tready);
    end
    s_os_axis_tlast = 1;
    cyc;
    #1;
    checks++;
    if (grant_o !== 2'd1 || m_axis_tuser !== 5'h01 || m_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL os_after_dllp: got grant=%0d user=%h valid=%b required 1 01 1", grant_o, m_axis_tuser, m_axis_tvalid);
    end
    cyc;
    s_os_axis_tvalid = 0;
    s_os_axis_tlast = 0;
    #1;
    checks++;
    if (grant_o !== 2'd0) begin
      errors++;
      $display("FAIL os_done: got grant=%0d required 0", grant_o);
    end
    link_reset;
  endtask

  task automatic test_skp_timer;
    link_up_i = 1;
    skp_en_i = 1;
    for (int k = 1; k <= 12; k++) begin
      cyc;
      #1;
      checks++;
      if (skp_req_o !== (k >= 9)) begin
        errors++;
        $display("FAIL skp_first_req_c%0d: got skp_req=%b required %b", k, skp_req_o, k >= 9);
      end
    end
    skp_ack_i = 1;
    cyc;
    skp_ack_i = 0;
    #1;
    checks++;
    if (skp_req_o !== 1'b0 || grant_o !== 2'd0) begin
      errors++;
      $display("FAIL skp_ack_drop: got skp_req=%b grant=%0d required 0 0", skp_req_o, grant_o);
    end
    for (int k = 14; k <= 17; k++) begin
      cyc;
      #1;
      checks++;
      if (skp_req_o !== (k == 17)) begin
        errors++;
        $display("FAIL skp_second_req_c%0d: got skp_req=%b required %b", k, skp_req_o, k == 17);
      end
    end
    link_reset;
  endtask

  task automatic test_skp_mid_packet;
    link_up_i = 1;
    skp_en_i = 1;
    m_axis_tready = 1;
    s_dllp_axis_tvalid = 1;
    s_dllp_axis_tlast = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc;
      s_dllp_axis_tdata = 32'hB000_0000 + k;
      #1;
      checks++;
      if (grant_o !== 2'd2 || skp_req_o !== 1'b0 || m_axis_tdata !== 32'hB000_0000 + k) begin
        errors++;
        $display("FAIL skp_no_cut_c%0d: got grant=%0d skp_req=%b data=%h required 2 0 %h",
                 k, grant_o, skp_req_o, m_axis_tdata, 32'hB000_0000 + k);
      end
    end
    s_dllp_axis_tlast = 1;
    cyc;
    s_dllp_axis_tlast = 0;
    #1;
    checks++;
    if (grant_o !== 2'd0) begin
      errors++;
      $display("FAIL skp_pkt_end: got grant=%0d required 0", grant_o);
    end
    for (int k = 12; k <= 14; k++) begin
      cyc;
      #1;
      checks++;
      if (grant_o !== 2'd3 || skp_req_o !== 1'b1 || s_dllp_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL skp_wait_c%0d: got grant=%0d skp_req=%b dllp_rdy=%b m_valid=%b required 3 1 0 0",
                 k, grant_o, skp_req_o, s_dllp_axis_tready, m_axis_tvalid);
      end
    end
    skp_ack_i = 1;
    cyc;
    skp_ack_i = 0;
    #1;
    checks++;
    if (grant_o !== 2'd0) begin
      errors++;
      $display("FAIL skp_ack_idle: got grant=%0d required 0", grant_o);
    end
    cyc;
    #1;
    checks++;
    if (grant_o !== 2'd2) begin
      errors++;
      $display("FAIL skp_dllp_after_ack: got grant=%0d required 2", grant_o);
    end
    s_dllp_axis_tlast = 1;
    cyc;
    link_reset;
  endtask

  task automatic test_skp_saturate;
    link_up_i = 1;
    skp_en_i = 1;
    repeat (40) cyc;
    #1;
    checks++;
    if (skp_req_o !== 1'b1) begin
      errors++;
      $display("FAIL sat_req_held: got skp_req=%b required 1", skp_req_o);
    end
    skp_en_i = 0;
    m_axis_tready = 1;
    s_dllp_axis_tvalid = 1;
    s_dllp_axis_tlast = 1;
    for (int a = 0; a < 3; a++) begin
      skp_ack_i = 1;
      cyc;
      skp_ack_i = 0;
      #1;
      checks++;
      if (grant_o !== 2'd0) begin
        errors++;
        $display("FAIL sat_ack%0d_idle: got grant=%0d required 0", a, grant_o);
      end
      cyc;
      #1;
      checks++;
      if (grant_o !== (a < 2 ? 2'd3 : 2'd2)) begin
        errors++;
        $display("FAIL sat_ack%0d_next: got grant=%0d required %0d", a, grant_o, a < 2 ? 3 : 2);
      end
    end
    cyc;
    link_reset;
  endtask

  task automatic test_link_drop;
    link_up_i = 1;
    skp_en_i = 1;
    repeat (9) cyc;
    #1;
    checks++;
    if (skp_req_o !== 1'b1) begin
      errors++;
      $display("FAIL drop_skp_setup: got skp_req=%b required 1", skp_req_o);
    end
    link_up_i = 0;
    cyc;
    #1;
    checks++;
    if (grant_o !== 2'd0 || skp_req_o !== 1'b0) begin
      errors++;
      $display("FAIL drop_skp_idle: got grant=%0d skp_req=%b required 0 0", grant_o, skp_req_o);
    end
    link_up_i = 1;
    skp_en_i = 0;
    repeat (2) cyc;
    #1;
    checks++;
    if (skp_req_o !== 1'b0) begin
      errors++;
      $display("FAIL drop_pending_cleared: got skp_req=%b required 0", skp_req_o);
    end
    m_axis_tready = 1;
    s_dllp_axis_tvalid = 1;
    s_dllp_axis_tlast = 0;
    cyc;
    link_up_i = 0;
    #1;
    checks++;
    if (grant_o !== 2'd2) begin
      errors++;
      $display("FAIL drop_dllp_start: got grant=%0d required 2", grant_o);
    end
    cyc;
    #1;
    checks++;
    if (grant_o !== 2'd2 || m_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL drop_dllp_continues: got grant=%0d m_valid=%b required 2 1", grant_o, m_axis_tvalid);
    end
    s_dllp_axis_tlast = 1;
    cyc;
    s_dllp_axis_tlast = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (grant_o !== 2'd0 || s_dllp_axis_tready !== 1'b0) begin
        errors++;
        $display("FAIL drop_no_new_dllp_c%0d: got grant=%0d dllp_rdy=%b required 0 0", k, grant_o, s_dllp_axis_tready);
      end
      cyc;
    end
    link_reset;
  endtask

  initial begin
    test_reset;
    test_dllp_packet;
    test_skp_timer;
    test_skp_mid_packet;
    test_skp_saturate;
    test_link_drop;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
